// File: rtl/mtx_sched_pkg.sv
// Shared types and default widths for the multi-tone phase scheduler.
package mtx_sched_pkg;

    localparam int DEF_PHASE_WIDTH  = 24;
    localparam int DEF_NSIG_WIDTH   = 24;
    localparam int DEF_NSYMB_WIDTH  = 16;
    localparam int DEF_TX_SYNC_BITS = 5;

    // tdata carries {phase2, phase1}
    localparam int DEF_TDATA_WIDTH  = 2 * DEF_PHASE_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/mtx_phase_acc.sv
// One phase channel: tracks the current symbol's start phase and increment
// and steps the running phase per sample and per symbol, using adders only.
module mtx_phase_acc #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,         // capture a new configuration
    input  logic             reload,       // restart a frame from the captured configuration
    input  logic             sample_step,  // next sample within the symbol
    input  logic             symbol_step,  // first sample of the next symbol
    input  logic [WIDTH-1:0] init_phase,
    input  logic [WIDTH-1:0] init_inc,
    input  logic [WIDTH-1:0] inc_step,
    input  logic [WIDTH-1:0] start_step,
    output logic [WIDTH-1:0] phase
);

    logic [WIDTH-1:0] base_phase, base_inc, inc_step_q, start_step_q;
    logic [WIDTH-1:0] sym_start, sym_inc, phase_q;
    logic [WIDTH-1:0] next_start;

    assign next_start = sym_start - start_step_q;
    assign phase      = phase_q;

    // Shadow configuration plus the per-symbol and per-sample phase state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: shadow config registers are reset as well, so tdata is never X after reset.
            base_phase   <= '0;
            base_inc     <= '0;
            inc_step_q   <= '0;
            start_step_q <= '0;
            sym_start    <= '0;
            sym_inc      <= '0;
            phase_q      <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments, so every register here sees pre-edge values.
            base_phase   <= init_phase;
            base_inc     <= init_inc;
            inc_step_q   <= inc_step;
            start_step_q <= start_step;
            sym_start    <= init_phase;
            sym_inc      <= init_inc;
            phase_q      <= init_phase;
        end else if (reload) begin
            sym_start <= base_phase;
            sym_inc   <= base_inc;
            phase_q   <= base_phase;
        end else if (symbol_step) begin
            sym_start <= next_start;
            sym_inc   <= sym_inc + inc_step_q;
            phase_q   <= next_start;
        end else if (sample_step) begin
            phase_q <= phase_q + sym_inc;
        end
    end

endmodule

// File: rtl/mtx_phase_sched.sv
// Frame scheduler for the two-tone DDS pair: emits NSYMB x NSIG phase-pair
// beats on an AXI-stream with backpressure, under start/stop control.
// Optional macro MTX_SCHED_CONT_EN adds a 'cont' input for back-to-back frames.
module mtx_phase_sched
    import mtx_sched_pkg::*;
#(
    parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
    parameter int NSIG_WIDTH   = DEF_NSIG_WIDTH,
    parameter int NSYMB_WIDTH  = DEF_NSYMB_WIDTH,
    parameter int TX_SYNC_BITS = DEF_TX_SYNC_BITS
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     stop,
`ifdef MTX_SCHED_CONT_EN
    input  logic                     cont,
`endif
    input  logic [NSIG_WIDTH-1:0]    cfg_nsig,
    input  logic [NSYMB_WIDTH-1:0]   cfg_nsymb,
    input  logic [PHASE_WIDTH-1:0]   cfg_start_ph,
    input  logic [PHASE_WIDTH-1:0]   cfg_start_inc,
    input  logic [PHASE_WIDTH-1:0]   cfg_dph_inc,
    input  logic [PHASE_WIDTH-1:0]   cfg_freq_shift,
    input  logic [PHASE_WIDTH-1:0]   cfg_nph_shift,
    output logic [2*PHASE_WIDTH-1:0] m_phase_tdata,
    output logic                     m_phase_tvalid,
    input  logic                     m_phase_tready,
    output logic                     m_phase_tlast,
    output logic                     m_phase_tuser,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic                     sync_ready,
    output logic [NSYMB_WIDTH-1:0]   symb_idx
);

    sched_state_e            state_q, state_d;
    logic [NSIG_WIDTH-1:0]   nsig_q, samp_cnt;
    logic [NSYMB_WIDTH-1:0]  nsymb_q, symb_cnt;
    logic [TX_SYNC_BITS-1:0] frame_cnt;
    logic                    stop_seen;
    logic                    cfg_ok, fire, last_sample, last_symb, cont_go;
    logic                    load, reload, sample_step, symbol_step;
    logic [PHASE_WIDTH-1:0]  phase1, phase2, tone2_inc;

    assign cfg_ok      = (cfg_nsig != '0) && (cfg_nsymb != '0);
    assign fire        = m_phase_tvalid && m_phase_tready;
    assign last_sample = (samp_cnt == nsig_q - NSIG_WIDTH'(1));
    assign last_symb   = (symb_cnt == nsymb_q - NSYMB_WIDTH'(1));
    assign tone2_inc   = cfg_start_inc + cfg_freq_shift;

`ifdef MTX_SCHED_CONT_EN
    // Restart only if no stop is pending or arriving on the final beat.
    assign cont_go = cont && !stop_seen && !stop;
`else
    assign cont_go = 1'b0;
`endif

    assign m_phase_tvalid = (state_q == RUN);
    assign m_phase_tuser  = m_phase_tvalid && (samp_cnt == '0);
    assign m_phase_tlast  = m_phase_tvalid && last_sample && (last_symb || stop_seen);
    assign m_phase_tdata  = {phase2, phase1};
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign sync_ready     = &frame_cnt;
    assign symb_idx       = symb_cnt;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and per-cycle datapath controls.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        load        = 1'b0;
        reload      = 1'b0;
        sample_step = 1'b0;
        symbol_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fire) begin
                    if (m_phase_tlast) begin
                        if (cont_go) reload  = 1'b1;
                        else         state_d = DRAIN;
                    end else if (last_sample) begin
                        symbol_step = 1'b1;
                    end else begin
                        sample_step = 1'b1;
                    end
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame shadow sizes, counters, sticky stop and status pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            nsig_q    <= '0;
            nsymb_q   <= '0;
            samp_cnt  <= '0;
            symb_cnt  <= '0;
            frame_cnt <= '1;
            stop_seen <= 1'b0;
            cfg_err   <= 1'b0;
            done      <= 1'b0;
        end else begin
            cfg_err <= (state_q == IDLE) && start && !cfg_ok;
            done    <= fire && m_phase_tlast;
            if (load) begin
                nsig_q    <= cfg_nsig;
                nsymb_q   <= cfg_nsymb;
                samp_cnt  <= '0;
                symb_cnt  <= '0;
                stop_seen <= 1'b0;
                frame_cnt <= frame_cnt + TX_SYNC_BITS'(1);
            end else if (reload) begin
                samp_cnt  <= '0;
                symb_cnt  <= '0;
                stop_seen <= 1'b0;
                frame_cnt <= frame_cnt + TX_SYNC_BITS'(1);
            end else begin
                if ((state_q == RUN) && stop) stop_seen <= 1'b1;
                if (symbol_step) begin
                    samp_cnt <= '0;
                    symb_cnt <= symb_cnt + NSYMB_WIDTH'(1);
                end else if (sample_step) begin
                    samp_cnt <= samp_cnt + NSIG_WIDTH'(1);
                end
            end
        end
    end

    // Tone 1: full start-phase / increment sequence.
    mtx_phase_acc #(.WIDTH(PHASE_WIDTH)) u_tone1 (
        .clk         (clk),
        .resetn      (resetn),
        .load        (load),
        .reload      (reload),
        .sample_step (sample_step),
        .symbol_step (symbol_step),
        .init_phase  (cfg_start_ph),
        .init_inc    (cfg_start_inc),
        .inc_step    (cfg_dph_inc),
        .start_step  (cfg_nph_shift),
        .phase       (phase1)
    );

    // Tone 2: every symbol starts at phase 0, increment offset by freq_shift.
    mtx_phase_acc #(.WIDTH(PHASE_WIDTH)) u_tone2 (
        .clk         (clk),
        .resetn      (resetn),
        .load        (load),
        .reload      (reload),
        .sample_step (sample_step),
        .symbol_step (symbol_step),
        .init_phase  ('0),
        .init_inc    (tone2_inc),
        .inc_step    (cfg_dph_inc),
        .start_step  ('0),
        .phase       (phase2)
    );

endmodule
